// File: rtl/load_scb_pkg.sv
// Shared definitions for the load scoreboard: load-type encodings and the
// data extension helper used by both the writeback and bypass paths.
package load_scb_pkg;

    // Data width the extension helper is built for; the scoreboard's XLEN
    // parameter defaults to this value and must match it.
    localparam int LOAD_XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // True for the five load encodings the MMU path understands.
    function automatic logic is_legal_func3(input logic [2:0] f3);
        logic ok;
        case (f3)
            LB, LH, LW, LBU, LHU: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Sign/zero-extend a raw MMU word according to the load type.
    function automatic logic [LOAD_XLEN-1:0] load_extend(input logic [2:0]           f3,
                                                         input logic [LOAD_XLEN-1:0] data);
        logic [LOAD_XLEN-1:0] res;
        case (f3)
            LB:      res = {{(LOAD_XLEN-8){data[7]}}, data[7:0]};
            LH:      res = {{(LOAD_XLEN-16){data[15]}}, data[15:0]};
            LBU:     res = {{(LOAD_XLEN-8){1'b0}}, data[7:0]};
            LHU:     res = {{(LOAD_XLEN-16){1'b0}}, data[15:0]};
            default: res = data; // LW; illegal types never enter the queue
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_scb_fifo.sv
// In-order queue of outstanding loads. Occupancy is tracked by a counter so
// full/empty never depend on pointer equality; pointers wrap modulo DEPTH.
module load_scb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // A full queue refuses pushes even in a cycle that pops.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Entry storage, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/load_scoreboard.sv
// Load-tracking scoreboard between decode and the MMU read port: in-order
// queue of outstanding loads, per-register pending counts for hazard
// queries, and a registered, extended writeback bus.
// Optional feature macro: LOAD_SCB_BYPASS_EN adds a same-cycle forwarding
// path (q_fwd1/q_fwd2/fwd_data) from the returning response to decode.
module load_scoreboard
    import load_scb_pkg::*;
#(
    parameter  int XLEN  = LOAD_XLEN,
    parameter  int NREGS = 32,
    parameter  int DEPTH = 4,
    localparam int RW    = $clog2(NREGS),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            cpu_clk_aon,
    input  logic            i_rst,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [RW-1:0]   iss_rd,
    input  logic [2:0]      iss_func3,
    input  logic [XLEN-1:0] iss_addr,
    output logic            mmu_rd_req,
    output logic [XLEN-1:0] mmu_rd_addr,
    input  logic            mmu_rd_valid,
    input  logic [XLEN-1:0] mmu_rd_data,
    input  logic [RW-1:0]   q_rs1,
    input  logic [RW-1:0]   q_rs2,
    output logic            q_busy1,
    output logic            q_busy2,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic [CW-1:0]   outstanding,
    output logic            err_unexp_rsp
`ifdef LOAD_SCB_BYPASS_EN
   ,output logic            q_fwd1
   ,output logic            q_fwd2
   ,output logic [XLEN-1:0] fwd_data
`endif
);

    logic [CW-1:0]   r_pend_cnt [NREGS];
    logic            r_wb_valid;
    logic [RW-1:0]   r_wb_reg;
    logic [XLEN-1:0] r_wb_data;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic [RW+2:0]   w_head;
    logic [RW-1:0]   w_head_rd;
    logic [2:0]      w_head_f3;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_ext;
    logic            w_busy1;
    logic            w_busy2;

    assign iss_ready   = !w_full;
    assign w_accept    = iss_valid && iss_ready && !i_rst;
    // Illegal load types complete the handshake but are dropped here.
    assign w_push      = w_accept && is_legal_func3(iss_func3);
    assign w_pop       = mmu_rd_valid && !w_empty && !i_rst;
    assign mmu_rd_req  = w_push;
    assign mmu_rd_addr = i_rst ? '0 : iss_addr;

    assign w_head_rd = w_head[RW+2:3];
    assign w_head_f3 = w_head[2:0];
    assign w_ext     = load_extend(w_head_f3, mmu_rd_data);

    load_scb_fifo #(
        .DEPTH (DEPTH),
        .W     (RW + 3)
    ) u_fifo (
        .clk     (cpu_clk_aon),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({iss_rd, iss_func3}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding)
    );

    // Per-register pending counts; register 0 is never tracked.
    always_ff @(posedge cpu_clk_aon) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_pend_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if ((w_push && (iss_rd == RW'(i))) && !(w_pop && (w_head_rd == RW'(i)))) begin
                    r_pend_cnt[i] <= r_pend_cnt[i] + CW'(1);
                end else if (!(w_push && (iss_rd == RW'(i))) && (w_pop && (w_head_rd == RW'(i)))) begin
                    r_pend_cnt[i] <= r_pend_cnt[i] - CW'(1);
                end else begin
                    r_pend_cnt[i] <= r_pend_cnt[i];
                end
            end
        end
    end

    // Writeback register: one-cycle strobe per popped response with rd != 0.
    always_ff @(posedge cpu_clk_aon) begin
        if (i_rst) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_pop && (w_head_rd != '0);
            if (w_pop) begin
                r_wb_reg  <= w_head_rd;
                r_wb_data <= w_ext;
            end
        end
    end

    // Sticky flag for a response that had no outstanding load to match.
    always_ff @(posedge cpu_clk_aon) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (mmu_rd_valid && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign wb_valid      = r_wb_valid;
    assign wb_reg        = r_wb_reg;
    assign wb_data       = r_wb_data;
    assign err_unexp_rsp = r_err;

    assign w_busy1 = (q_rs1 != '0) && (r_pend_cnt[q_rs1] != '0);
    assign w_busy2 = (q_rs2 != '0) && (r_pend_cnt[q_rs2] != '0);

`ifdef LOAD_SCB_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // The last pending load to a queried register is returning right now, so
    // decode can take the extended data instead of stalling.
    assign w_fwd1   = w_pop && (w_head_rd == q_rs1) && (q_rs1 != '0) && (r_pend_cnt[q_rs1] == CW'(1));
    assign w_fwd2   = w_pop && (w_head_rd == q_rs2) && (q_rs2 != '0) && (r_pend_cnt[q_rs2] == CW'(1));
    assign q_busy1  = w_busy1 && !w_fwd1;
    assign q_busy2  = w_busy2 && !w_fwd2;
    assign q_fwd1   = w_fwd1;
    assign q_fwd2   = w_fwd2;
    assign fwd_data = w_ext;
`else
    assign q_busy1 = w_busy1;
    assign q_busy2 = w_busy2;
`endif

endmodule
